// File: rtl/counter_report_ctrl.sv
// Report sequencer for the dual-latch counter: arbitrates latch registers, sends
// tag + little-endian payload frames on the byte link and handles host acks/commands.
module counter_report_ctrl #(
  parameter int unsigned Width      = 40,
  parameter int unsigned AckTimeout = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy1,
  input  logic             rdy2,
  input  logic [Width-1:0] latch1_val,
  input  logic [Width-1:0] latch2_val,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             reset_latch1,
  output logic             reset_latch2,
  output logic             sw_latch1,
  output logic             sw_latch2,
  output logic             rx_err,
  output logic             busy
);

  localparam int unsigned NBytes = Width / 8;
  localparam int unsigned IdxW   = (NBytes > 1) ? $clog2(NBytes) : 1;

  typedef enum logic [1:0] {StIdle, StTag, StData, StWaitAck} state_e;

  state_e                       state_q, state_d;
  logic [NBytes-1:0][7:0]       snap_q, snap_d;
  logic [IdxW-1:0]              idx_q, idx_d;
  logic [31:0]                  tmo_q, tmo_d;
  logic                         rr_q, rr_d;     // 0: channel 1 next on a tie
  logic                         chan_q, chan_d; // 0: channel 1, 1: channel 2
  logic                         armed1_q, armed1_d, armed2_q, armed2_d;
  logic                         rst1_q, rst1_d, rst2_q, rst2_d;
  logic                         sw1_q, sw1_d, sw2_q, sw2_d, err_q, err_d;

  logic elig1, elig2, ack, is_cmd;

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    rr_d     = rr_q;
    chan_d   = chan_q;
    // Rearm only once the latch has actually been released
    armed1_d = armed1_q | ~rdy1;
    armed2_d = armed2_q | ~rdy2;
    rst1_d   = 1'b0;
    rst2_d   = 1'b0;

    elig1  = rdy1 & armed1_q;
    elig2  = rdy2 & armed2_q;
    ack    = rx_valid && (rx_data[7:1] == 7'd0) && (state_q == StWaitAck) &&
             (rx_data[0] == chan_q);
    is_cmd = (rx_data == 8'h02) || (rx_data == 8'h03);
    sw1_d  = rx_valid && (rx_data == 8'h02);
    sw2_d  = rx_valid && (rx_data == 8'h03);
    err_d  = rx_valid && !is_cmd && !ack;

    unique case (state_q)
      StIdle: begin
        if (elig1 || elig2) begin
          chan_d = (elig1 && elig2) ? rr_q : elig2;
          if (elig1 && elig2) rr_d = ~rr_q;
          snap_d  = chan_d ? latch2_val : latch1_val;
          if (chan_d) armed2_d = 1'b0;
          else        armed1_d = 1'b0;
          state_d = StTag;
        end
      end
      StTag: begin
        if (tx_ready) begin
          idx_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (tx_ready) begin
          if (idx_q == IdxW'(NBytes - 1)) begin
            tmo_d   = '0;
            state_d = StWaitAck;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StWaitAck: begin
        if (ack) begin
          rst1_d  = ~chan_q;
          rst2_d  = chan_q;
          state_d = StIdle;
        end else if (AckTimeout != 0) begin
          if (tmo_q == AckTimeout - 1) begin
            tmo_d   = '0;
            state_d = StTag;
          end else begin
            tmo_d = tmo_q + 32'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      snap_q   <= '0;
      idx_q    <= '0;
      tmo_q    <= '0;
      rr_q     <= 1'b0;
      chan_q   <= 1'b0;
      armed1_q <= 1'b1;
      armed2_q <= 1'b1;
      rst1_q   <= 1'b0;
      rst2_q   <= 1'b0;
      sw1_q    <= 1'b0;
      sw2_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      rr_q     <= rr_d;
      chan_q   <= chan_d;
      armed1_q <= armed1_d;
      armed2_q <= armed2_d;
      rst1_q   <= rst1_d;
      rst2_q   <= rst2_d;
      sw1_q    <= sw1_d;
      sw2_q    <= sw2_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    case (state_q)
      StTag: begin
        tx_valid = 1'b1;
        tx_data  = {7'd0, chan_q};
      end
      StData: begin
        tx_valid = 1'b1;
        tx_data  = snap_q[idx_q];
      end
      default: ;
    endcase
  end

  assign busy         = (state_q != StIdle);
  assign reset_latch1 = rst1_q;
  assign reset_latch2 = rst2_q;
  assign sw_latch1    = sw1_q;
  assign sw_latch2    = sw2_q;
  assign rx_err       = err_q;

endmodule

// File: tb/tb_counter_report_ctrl.sv
// Directed bench for counter_report_ctrl with a 16-cycle ack timeout.
module tb_counter_report_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy1, rdy2;
  logic [39:0] latch1_val, latch2_val;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        reset_latch1, reset_latch2, sw_latch1, sw_latch2, rx_err, busy;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  counter_report_ctrl #(.Width(40), .AckTimeout(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rdy1         (rdy1),
    .rdy2         (rdy2),
    .latch1_val   (latch1_val),
    .latch2_val   (latch2_val),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .reset_latch1 (reset_latch1),
    .reset_latch2 (reset_latch2),
    .sw_latch1    (sw_latch1),
    .sw_latch2    (sw_latch2),
    .rx_err       (rx_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic expect_frame(input string name, input logic [7:0] tag, input logic [39:0] v);
    chk({name, " tag"}, {tx_valid, tx_data}, {1'b1, tag});
    step();
    for (int i = 0; i < 5; i++) begin
      chk({name, " byte"}, {tx_valid, tx_data}, {1'b1, v[8*i +: 8]});
      step();
    end
    chk({name, " end"}, {busy, tx_valid}, 2'b10);
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0; tx_ready = 1'b1;
    latch1_val = '0; latch2_val = '0; rx_data = '0; rx_valid = 1'b0;
    step(); step();
    chk("reset outs", {busy, tx_valid, tx_data, reset_latch1, reset_latch2,
                       sw_latch1, sw_latch2, rx_err}, '0);
    rst_n = 1'b1;
    step();
    chk("idle after reset", {busy, tx_valid}, 2'b00);

    // Single latch
    latch1_val = 40'h12_3456_789A; rdy1 = 1'b1;
    step();
    expect_frame("single", 8'h00, 40'h12_3456_789A);
    host(8'h00);
    chk("single ack", {reset_latch1, reset_latch2, busy}, 3'b100);
    rdy1 = 1'b0;
    step();
    chk("single ack 1 wide", reset_latch1, 1'b0);

    // Arbitration: tie goes to channel 1 first
    latch1_val = 40'hA5A4A3A2A1; latch2_val = 40'hB5B4B3B2B1;
    rdy1 = 1'b1; rdy2 = 1'b1;
    step();
    expect_frame("arb1 ch1", 8'h00, 40'hA5A4A3A2A1);
    host(8'h00);
    chk("arb1 ack1", reset_latch1, 1'b1);
    rdy1 = 1'b0;
    step();
    expect_frame("arb1 ch2", 8'h01, 40'hB5B4B3B2B1);
    host(8'h01);
    chk("arb1 ack2", {reset_latch1, reset_latch2}, 2'b01);
    rdy2 = 1'b0;
    step();

    // Second tie: channel 2 first
    rdy1 = 1'b1; rdy2 = 1'b1;
    step();
    expect_frame("arb2 ch2", 8'h01, 40'hB5B4B3B2B1);
    host(8'h00);
    chk("wrong chan ack err", {rx_err, busy, reset_latch1}, 3'b110);
    host(8'h01);
    chk("arb2 ack2", {rx_err, reset_latch2}, 2'b01);
    rdy2 = 1'b0;
    step();
    expect_frame("arb2 ch1", 8'h00, 40'hA5A4A3A2A1);
    host(8'h00);
    chk("arb2 ack1", reset_latch1, 1'b1);
    rdy1 = 1'b0;
    step();

    // Backpressure 1-0-0-1 during DATA
    latch1_val = 40'h01_0203_0405; rdy1 = 1'b1;
    step();
    chk("bp tag", {tx_valid, tx_data}, {1'b1, 8'h00});
    step();
    chk("bp b0", {tx_valid, tx_data}, {1'b1, 8'h05});
    step();
    tx_ready = 1'b0;
    chk("bp b1 a", {tx_valid, tx_data}, {1'b1, 8'h04});
    step();
    chk("bp b1 b", {tx_valid, tx_data}, {1'b1, 8'h04});
    step();
    tx_ready = 1'b1;
    chk("bp b1 c", {tx_valid, tx_data}, {1'b1, 8'h04});
    step();
    chk("bp b2", {tx_valid, tx_data}, {1'b1, 8'h03});
    step();
    chk("bp b3", {tx_valid, tx_data}, {1'b1, 8'h02});
    step();
    chk("bp b4", {tx_valid, tx_data}, {1'b1, 8'h01});
    step();
    chk("bp done", {busy, tx_valid}, 2'b10);
    host(8'h00);
    rdy1 = 1'b0;
    step();

    // Timeout retry, resend from the snapshot even though the source changed
    latch1_val = 40'hCA_FEBA_BE01; rdy1 = 1'b1;
    step();
    latch1_val = 40'h99_9999_9999;
    expect_frame("tmo first", 8'h00, 40'hCA_FEBA_BE01);
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      seen = seen | tx_valid;
      step();
    end
    chk("tmo quiet 16", {seen, busy}, 2'b01);
    expect_frame("tmo resend", 8'h00, 40'hCA_FEBA_BE01);
    host(8'h00);
    chk("tmo ack", {reset_latch1, busy}, 2'b10);

    // Rearm guard: latch still held, no new frame
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      seen = seen | busy;
    end
    chk("rearm guard", seen, 1'b0);
    latch1_val = 40'h55_6677_8899;
    rdy1 = 1'b0;
    step();
    rdy1 = 1'b1;
    step();
    // Rearmed frame, host 0x03 injected mid-DATA
    chk("rearm tag", {tx_valid, tx_data}, {1'b1, 8'h00});
    step();
    for (int i = 0; i < 5; i++) begin
      logic [39:0] v;
      v = 40'h55_6677_8899;
      rx_valid = (i == 2);
      rx_data  = 8'h03;
      chk("rearm byte", {tx_valid, tx_data}, {1'b1, v[8*i +: 8]});
      step();
      if (i == 2) chk("sw2 in data", {sw_latch2, sw_latch1, rx_err}, 3'b100);
    end
    rx_valid = 1'b0;
    chk("sw2 1 wide", {sw_latch2, busy, tx_valid}, 3'b010);
    host(8'h00);
    rdy1 = 1'b0;
    step();

    // Commands in IDLE
    host(8'h02);
    chk("sw1", {sw_latch1, sw_latch2, rx_err}, 3'b100);
    step();
    chk("sw1 1 wide", sw_latch1, 1'b0);
    host(8'h01);
    chk("idle 01 err", {rx_err, reset_latch2, busy}, 3'b100);
    host(8'h7F);
    chk("7f err", rx_err, 1'b1);
    step();
    chk("err 1 wide", rx_err, 1'b0);

    // Async reset mid-DATA
    latch1_val = 40'h11_2233_4455; rdy1 = 1'b1;
    step();
    step();
    chk("pre-reset data", {tx_valid, tx_data}, {1'b1, 8'h55});
    #2 rst_n = 1'b0;
    #1 chk("async reset", {tx_valid, busy, tx_data}, '0);
    step();
    rst_n = 1'b1;
    chk("post reset idle", busy, 1'b0);
    step();
    chk("post reset tag", {tx_valid, tx_data}, {1'b1, 8'h00});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/counter_report_ctrl.md
Name: counter_report_ctrl

Overview:
- Sequences the dual-latch counter block toward the USB byte link.
- Arbitrates between the two latch registers and serialises each latched value as a tag byte plus a little-endian payload.
- Waits for the host acknowledge byte, then pulses the matching latch reset.
- Decodes the host software-trigger commands 0x02/0x03 into latch strobes.

Parameters:
- pWIDTH, 40: latched counter width in bits; must be a multiple of 8 and in the range 8..64.
- pACK_TIMEOUT, 1000000: cycles to wait for an acknowledge before the frame is re-sent; 0 disables the timeout.

Ports:
- iCLK  input  1  system clock; all state changes on its rising edge.
- iRST_N  input  1  asynchronous active-low reset.
- iRdy1  input  1  register 1 holds a latched value.
- iRdy2  input  1  register 2 holds a latched value.
- iLatch1Val  input  pWIDTH  register 1 latched value.
- iLatch2Val  input  pWIDTH  register 2 latched value.
- oTxData  output  8  byte to host.
- oTxValid  output  1  oTxData is valid.
- iTxReady  input  1  link accepts a byte; a transfer occurs when oTxValid and iTxReady are both high at a rising edge.
- iRxData  output-side partner: input  8  byte from host.
- iRxValid  input  1  single-cycle strobe qualifying iRxData.
- oResetLatch1  output  1  one-cycle pulse that clears the register 1 latch.
- oResetLatch2  output  1  one-cycle pulse that clears the register 2 latch.
- oSwLatch1  output  1  one-cycle software latch strobe for register 1.
- oSwLatch2  output  1  one-cycle software latch strobe for register 2.
- oRxErr  output  1  one-cycle pulse on an unexpected host byte.
- oBusy  output  1  FSM is not in IDLE.

Behaviour:
- Reset (iRST_N low, asynchronous): FSM=IDLE; all outputs 0; oTxData=0x00; snapshot register=0; byte index=0; timeout counter=0; rr pointer=channel 1; armed1=armed2=1.
- Arming:
  - armedN clears when channel N is granted.
  - armedN sets on any cycle where iRdyN=0.
  - The block never re-sends a value whose latch is still locked after its reset pulse.
- IDLE, grant:
  - Channel N is eligible when iRdyN && armedN.
  - If one channel is eligible, grant it.
  - If both are eligible, grant the channel named by rr; rr then points to the other channel.
  - On grant, capture iLatchNVal into the snapshot register, set chan=N, and go to TAG.
- TAG:
  - Drive oTxValid=1 with oTxData=chan-1 (0x00 or 0x01).
  - On transfer go to DATA with byte index=0.
- DATA:
  - Drive oTxData=snapshot[8*idx+:8] with oTxValid=1.
  - On transfer, idx increments.
  - After byte pWIDTH/8-1 transfers, go to WAIT_ACK and clear the timeout counter.
  - oTxValid and oTxData stay stable while iTxReady=0.
  - No bubble cycle between bytes: a frame takes exactly 1+pWIDTH/8 transfer cycles when iTxReady is held high.
- WAIT_ACK:
  - iRxValid with iRxData==chan-1: pulse oResetLatchN in the next cycle, then go to IDLE.
  - Timeout counter reaches pACK_TIMEOUT (nonzero): go to TAG and re-send the same snapshot. Re-reading the source is forbidden.
- Host command decode, active in every state:
  - 0x02: pulse oSwLatch1 in the next cycle.
  - 0x03: pulse oSwLatch2 in the next cycle.
  - 0x00/0x01 outside WAIT_ACK, or not matching chan: ignored and oRxErr pulses.
  - Bytes 0x04..0xFF: ignored and oRxErr pulses.
- All pulse outputs are registered, exactly one cycle wide.
- Simultaneous events:
  - Ack and timeout in the same cycle: ack wins.
  - iRdyN rising while the other channel is being sent: serviced on the next IDLE.
  - A channel may be granted in the cycle after IDLE is re-entered (IDLE lasts at least 1 cycle).
- iRdyN dropping mid-frame (external reset): frame completes with the snapshot; ack handling is unchanged.
- iRST_N asserted mid-frame: abort immediately with no further bytes; after release, start from IDLE.

Test Plan:
- Single latch:
  - Stimulus: iRdy1=1, iLatch1Val=40'h12_3456_789A, iTxReady=1.
  - Required: bytes 00,9A,78,56,34,12 on 6 consecutive cycles.
  - Then host 0x00 -> oResetLatch1 pulses 1 cycle, oBusy=0.
- Arbitration:
  - Stimulus: iRdy1 and iRdy2 rise in the same cycle out of reset.
  - Required: channel 1 frame first (tag 00), ack, then channel 2 frame (tag 01).
  - Repeat the simultaneous rise: channel 2 goes first.
- Backpressure:
  - Stimulus: toggle iTxReady 1-0-0-1 during DATA.
  - Required: oTxData holds each byte until transfer; no byte is lost or duplicated.
- Timeout retry:
  - Stimulus: pACK_TIMEOUT=16, no ack.
  - Required: the identical 6-byte frame is re-sent 16 cycles after the last byte; an ack then ends the frame normally.
- Rearm guard:
  - Stimulus: after ack, hold iRdy1=1 for 50 cycles.
  - Required: no new frame.
  - Then drop iRdy1 for 1 cycle and raise it again -> a new frame is sent.
- Commands and reset:
  - Host 0x02 -> oSwLatch1 pulse.
  - Host 0x03 during DATA -> oSwLatch2 pulse with the frame undisturbed.
  - Host 0x01 in IDLE, and host 0x7F -> oRxErr pulses.
  - iRST_N low mid-DATA -> oTxValid=0 asynchronously.
